// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants and types for the ALU execute-stage controller.
// Optional feature macro: ALU_EXEC_SKIP_EN (early completion of non-writing instructions).
package alu_exec_ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;

   localparam logic [1:0] CZ_ALW = 2'b00;
   localparam logic [1:0] CZ_C   = 2'b10;
   localparam logic [1:0] CZ_Z   = 2'b01;

   localparam logic ALU_ADD  = 1'b0;
   localparam logic ALU_NAND = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } alu_state_t;

   function automatic logic [15:0] sext6(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction

endpackage

// File: rtl/alu_exec_cond.sv
// Write-condition and legality decode for one arithmetic/logic instruction.
module alu_exec_cond
   import alu_exec_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [1:0] cz,
   input  logic       flag_c,
   input  logic       flag_z,
   output logic       wr,
   output logic       err
);

   always_comb begin
      wr  = 1'b0;
      err = 1'b0;
      case (opcode)
         // ADI has no condition field, so cz==11 is not illegal for it
         OP_ADI: wr = 1'b1;
         OP_ADD, OP_NDU: begin
            case (cz)
               CZ_ALW:  wr = 1'b1;
               CZ_C:    wr = flag_c;
               CZ_Z:    wr = flag_z;
               default: err = 1'b1;
            endcase
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute controller for ADD/ADC/ADZ/ADI/NDU/NDC/NDZ; owns carry/zero flags.
// Optional feature macro: ALU_EXEC_SKIP_EN lets non-writing instructions finish in EXEC.
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [1:0]  cz,
   input  logic [2:0]  ra,
   input  logic [2:0]  rb,
   input  logic [2:0]  rc,
   input  logic [5:0]  imm6,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [2:0]  rf_ra1,
   output logic [2:0]  rf_ra2,
   input  logic [15:0] rf_rd1,
   input  logic [15:0] rf_rd2,
   output logic        rf_we,
   output logic [2:0]  rf_wa,
   output logic [15:0] rf_wd,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_op,
   input  logic [15:0] alu_y,
   input  logic        alu_c,
   output logic        flag_c,
   output logic        flag_z,
   output alu_state_t  state_dbg
);

   // start/ready: an instruction is taken on a rising edge where start & ready are both 1;
   // ready is 1 only in IDLE, so start is ignored in every other state.

   alu_state_t state;
   logic [3:0] op_q;
   logic [1:0] cz_q;
   logic [5:0] imm_q;
   logic       c_q;
   logic       wr_q;
   logic [3:0] cond_op;
   logic [1:0] cond_cz;
   logic       cond_wr;
   logic       cond_err;

   assign ready     = (state == ST_IDLE);
   assign state_dbg = state;

   // Decode the live inputs while idle (legality at accept), latched fields afterwards.
   // Flags only move on the WB edge, so READ-cycle flags equal the EXEC-entry flags.
   assign cond_op = ready ? opcode : op_q;
   assign cond_cz = ready ? cz : cz_q;

   alu_exec_cond u_cond (
      .opcode (cond_op),
      .cz     (cond_cz),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .wr     (cond_wr),
      .err    (cond_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_q   <= '0;
         cz_q   <= '0;
         imm_q  <= '0;
         c_q    <= 1'b0;
         wr_q   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         rf_ra1 <= '0;
         rf_ra2 <= '0;
         rf_we  <= 1'b0;
         rf_wa  <= '0;
         rf_wd  <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= ALU_ADD;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q   <= opcode;
                  cz_q   <= cz;
                  imm_q  <= imm6;
                  rf_ra1 <= ra;
                  rf_ra2 <= rb;
                  rf_wa  <= (opcode == OP_ADI) ? rb : rc;
                  alu_op <= (opcode == OP_NDU) ? ALU_NAND : ALU_ADD;
                  if (cond_err) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_WB;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               alu_a <= rf_rd1;
               alu_b <= (op_q == OP_ADI) ? sext6(imm_q) : rf_rd2;
               wr_q  <= cond_wr;
`ifdef ALU_EXEC_SKIP_EN
               done  <= ~cond_wr;
`endif
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               rf_wd <= alu_y;
               c_q   <= alu_c;
               rf_we <= wr_q;
               done  <= 1'b1;
               state <= ST_WB;
`ifdef ALU_EXEC_SKIP_EN
               if (!wr_q) begin
                  done  <= 1'b0;
                  state <= ST_IDLE;
               end
`endif
            end
            ST_WB: begin
               // rf_we doubles as the latched write condition for the flag update
               if (rf_we) begin
                  flag_z <= (rf_wd == 16'h0000);
                  if (op_q != OP_NDU) flag_c <= c_q;
               end
               rf_we <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a register-file and ALU environment model.
module tb_alu_exec_ctrl;
   import alu_exec_ctrl_pkg::*;

`ifdef ALU_EXEC_SKIP_EN
   localparam logic [15:0] NOWR_LAT = 16'd2;
`else
   localparam logic [15:0] NOWR_LAT = 16'd3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  opcode;
   logic [1:0]  cz;
   logic [2:0]  ra, rb, rc;
   logic [5:0]  imm6;
   logic        ready, done, err;
   logic [2:0]  rf_ra1, rf_ra2, rf_wa;
   logic [15:0] rf_rd1, rf_rd2, rf_wd;
   logic        rf_we;
   logic [15:0] alu_a, alu_b, alu_y;
   logic        alu_op, alu_c;
   logic        flag_c, flag_z;
   alu_state_t  state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] r_lat, r_wd;
   logic [2:0]  r_wa;
   logic        r_we, r_err, r_rdy;

   // clock / reset block
   always #5 clk = ~clk;

   // environment: register file and ALU
   logic [15:0] rf_mem [8] = '{16'h0000, 16'h7FFF, 16'h0001, 16'h0000,
                               16'hFFFF, 16'h0001, 16'h0005, 16'h0000};
   assign rf_rd1 = rf_mem[rf_ra1];
   assign rf_rd2 = rf_mem[rf_ra2];
   always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;
   assign {alu_c, alu_y} = alu_op ? {1'b0, ~(alu_a & alu_b)}
                                  : ({1'b0, alu_a} + {1'b0, alu_b});

   alu_exec_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .cz(cz),
      .ra(ra), .rb(rb), .rc(rc), .imm6(imm6), .ready(ready), .done(done), .err(err),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_y(alu_y), .alu_c(alu_c), .flag_c(flag_c), .flag_z(flag_z),
      .state_dbg(state_dbg)
   );

   // scoreboard check
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver: issue one instruction, record the completion cycle and outputs
   task automatic exec(input logic [3:0] op, input logic [1:0] c, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input logic [5:0] im);
      @(negedge clk);
      opcode = op; cz = c; ra = a; rb = b; rc = d; imm6 = im; start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      opcode = 4'($urandom_range(0, 15));
      cz     = 2'($urandom_range(0, 3));
      ra     = 3'($urandom_range(0, 7));
      rb     = 3'($urandom_range(0, 7));
      rc     = 3'($urandom_range(0, 7));
      imm6   = 6'($urandom_range(0, 63));
      r_lat = 16'd0; r_we = 1'b0; r_wa = 3'd0; r_wd = 16'd0; r_err = 1'b0;
      for (int i = 1; i <= 8 && r_lat == 16'd0; i++) begin
         @(negedge clk);
         if (done) begin
            r_lat = 16'(i); r_we = rf_we; r_wa = rf_wa; r_wd = rf_wd; r_err = err;
         end
      end
      @(negedge clk);
      r_rdy = ready;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; opcode = 4'd0; cz = 2'd0;
      ra = 3'd0; rb = 3'd0; rc = 3'd0; imm6 = 6'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 16'(ready), 16'd1);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_err", 16'(err), 16'd0);
      chk("rst_we", 16'(rf_we), 16'd0);
      chk("rst_wa", 16'(rf_wa), 16'd0);
      chk("rst_wd", rf_wd, 16'd0);
      chk("rst_ra1", 16'(rf_ra1), 16'd0);
      chk("rst_alu_a", alu_a, 16'd0);
      chk("rst_alu_op", 16'(alu_op), 16'd0);
      chk("rst_flags", {14'd0, flag_c, flag_z}, 16'd0);
      chk("rst_state", 16'(state_dbg), 16'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // ADD r1+r2 -> r3: 0x7FFF + 1
      exec(OP_ADD, CZ_ALW, 3'd1, 3'd2, 3'd3, 6'd0);
      chk("add1_lat", r_lat, 16'd3);
      chk("add1_we", 16'(r_we), 16'd1);
      chk("add1_wa", 16'(r_wa), 16'd3);
      chk("add1_wd", r_wd, 16'h8000);
      chk("add1_err", 16'(r_err), 16'd0);
      chk("add1_rdy", 16'(r_rdy), 16'd1);
      chk("add1_flags", {14'd0, flag_c, flag_z}, 16'b00);

      // ADD 0xFFFF + 1 -> r0: wraps to zero with carry
      exec(OP_ADD, CZ_ALW, 3'd4, 3'd5, 3'd0, 6'd0);
      chk("addwrap_wd", r_wd, 16'h0000);
      chk("addwrap_we", 16'(r_we), 16'd1);
      chk("addwrap_flags", {14'd0, flag_c, flag_z}, 16'b11);

      // ADC with carry set writes
      exec(OP_ADD, CZ_C, 3'd1, 3'd2, 3'd3, 6'd0);
      chk("adc1_we", 16'(r_we), 16'd1);
      chk("adc1_wd", r_wd, 16'h8000);
      chk("adc1_flags", {14'd0, flag_c, flag_z}, 16'b00);

      // ADC with carry clear: no write, flags held
      exec(OP_ADD, CZ_C, 3'd4, 3'd5, 3'd3, 6'd0);
      chk("adc0_lat", r_lat, NOWR_LAT);
      chk("adc0_we", 16'(r_we), 16'd0);
      chk("adc0_flags", {14'd0, flag_c, flag_z}, 16'b00);
      chk("adc0_r3", rf_mem[3], 16'h8000);

      // ADZ with zero clear: no write
      exec(OP_ADD, CZ_Z, 3'd1, 3'd2, 3'd3, 6'd0);
      chk("adz0_lat", r_lat, NOWR_LAT);
      chk("adz0_we", 16'(r_we), 16'd0);
      chk("adz0_rdy", 16'(r_rdy), 16'd1);

      // ADI r7 <- r6 + sext(6'b111111) = 5 - 1
      exec(OP_ADI, CZ_ALW, 3'd6, 3'd7, 3'd2, 6'b111111);
      chk("adi_wa", 16'(r_wa), 16'd7);
      chk("adi_wd", r_wd, 16'h0004);
      chk("adi_flags", {14'd0, flag_c, flag_z}, 16'b10);
      chk("adi_r7", rf_mem[7], 16'h0004);

      // NDU 0xFFFF nand 0xFFFF -> r0: zero set, carry untouched
      exec(OP_NDU, CZ_ALW, 3'd4, 3'd4, 3'd0, 6'd0);
      chk("ndu_wd", r_wd, 16'h0000);
      chk("ndu_we", 16'(r_we), 16'd1);
      chk("ndu_flags", {14'd0, flag_c, flag_z}, 16'b11);

      // clear flags, then NDZ with zero clear: no write
      exec(OP_ADD, CZ_ALW, 3'd1, 3'd2, 3'd3, 6'd0);
      chk("add2_flags", {14'd0, flag_c, flag_z}, 16'b00);
      exec(OP_NDU, CZ_Z, 3'd4, 3'd4, 3'd3, 6'd0);
      chk("ndz0_we", 16'(r_we), 16'd0);
      chk("ndz0_lat", r_lat, NOWR_LAT);
      chk("ndz0_r3", rf_mem[3], 16'h8000);

      // illegal opcode and illegal cz
      exec(4'b1111, CZ_ALW, 3'd1, 3'd2, 3'd3, 6'd0);
      chk("illop_lat", r_lat, 16'd1);
      chk("illop_err", 16'(r_err), 16'd1);
      chk("illop_we", 16'(r_we), 16'd0);
      chk("illop_rdy", 16'(r_rdy), 16'd1);
      chk("illop_err_clr", 16'(err), 16'd0);
      exec(OP_ADD, 2'b11, 3'd4, 3'd5, 3'd0, 6'd0);
      chk("illcz_lat", r_lat, 16'd1);
      chk("illcz_err", 16'(r_err), 16'd1);
      chk("illcz_flags", {14'd0, flag_c, flag_z}, 16'b00);

      // ADI ignores cz even when it is 11: r3 <- 0x7FFF + 1
      exec(OP_ADI, 2'b11, 3'd1, 3'd3, 3'd6, 6'b000001);
      chk("adi11_lat", r_lat, 16'd3);
      chk("adi11_err", 16'(r_err), 16'd0);
      chk("adi11_wd", r_wd, 16'h8000);
      chk("adi11_wa", 16'(r_wa), 16'd3);

      // reset during EXEC: no write, flags cleared
      exec(OP_ADD, CZ_ALW, 3'd4, 3'd5, 3'd0, 6'd0);
      chk("pre_rst_flags", {14'd0, flag_c, flag_z}, 16'b11);
      @(negedge clk);
      opcode = OP_ADD; cz = CZ_ALW; ra = 3'd1; rb = 3'd2; rc = 3'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_state", 16'(state_dbg), 16'(ST_EXEC));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 16'(rf_we), 16'd0);
      chk("mid_rst_ready", 16'(ready), 16'd1);
      chk("mid_rst_flags", {14'd0, flag_c, flag_z}, 16'b00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_we", 16'(rf_we), 16'd0);
      end
      chk("post_rst_ready", 16'(ready), 16'd1);
      chk("post_rst_done", 16'(done), 16'd0);
      chk("post_rst_r7", rf_mem[7], 16'h0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
